// File: rtl/dmem_mover_pkg.sv
// Shared definitions for the data-memory block mover: state encoding,
// mode values, address step and the default word-count width.
package dmem_mover_pkg;

   localparam int          DEFAULT_LEN_W = 8;
   localparam logic        MODE_COPY     = 1'b0;
   localparam logic        MODE_FILL     = 1'b1;
   localparam logic [31:0] WORD_STEP     = 32'd4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_RD   = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Byte address forced onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/dmem_addr_counter.sv
// Word-address pointer: loads a word-aligned start address and steps by one
// word per request, wrapping modulo 2^32.
module dmem_addr_counter
   import dmem_mover_pkg::*;
(
   input  logic        clock,
   input  logic        clr,
   input  logic        load,
   input  logic [31:0] load_addr,
   input  logic        step,
   output logic [31:0] ptr
);

   logic [31:0] ptr_reg;

   // Load has priority over step; plain 32-bit add gives the wrap for free.
   always_ff @(posedge clock or posedge clr) begin
      if (clr) begin
         ptr_reg <= '0;
      end else if (load) begin
         ptr_reg <= word_align(load_addr);
      end else if (step) begin
         ptr_reg <= ptr_reg + WORD_STEP;
      end
   end

   assign ptr = ptr_reg;

endmodule

// File: rtl/dmem_block_mover.sv
// Data-memory bus initiator: copies a block of words between two address
// ranges, or fills a range with a constant, sharing the CPU's data port via
// a request/grant handshake. Every output comes straight from a register.
module dmem_block_mover
   import dmem_mover_pkg::*;
#(
   parameter int LEN_W = DEFAULT_LEN_W
)
(
   input  logic             clock,
   input  logic             clr,
   input  logic             start,
   input  logic             mode,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   input  logic [31:0]      fill_data,
   output logic             bus_req,
   input  logic             bus_gnt,
   output logic [31:0]      addr,
   output logic [31:0]      datain,
   output logic             we,
   input  logic [31:0]      dataout,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] words_done
);

   localparam int SRC = 0;
   localparam int DST = 1;

   state_t           state_reg, state_next;
   logic             mode_reg;
   logic [LEN_W-1:0] len_reg;
   logic [31:0]      fill_reg;
   logic [LEN_W-1:0] words_done_reg;

   // Output registers; data_reg doubles as the captured read word and the
   // write-data driver, and is zero whenever the mover is not writing.
   logic [31:0]      data_reg, data_next;
   logic [31:0]      addr_reg, addr_next;
   logic             we_reg, we_next;
   logic             bus_req_reg, bus_req_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   logic             ptr_load;
   logic [1:0]       ptr_step;
   logic [31:0]      ptr_load_addr [2];
   logic [31:0]      ptr_val [2];

   logic             accept;
   logic             last_word;
   logic             wd_inc;

   assign ptr_load_addr[SRC] = src_addr;
   assign ptr_load_addr[DST] = dst_addr;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ptr
         dmem_addr_counter u_cnt (
            .clock     (clock),
            .clr       (clr),
            .load      (ptr_load),
            .load_addr (ptr_load_addr[gi]),
            .step      (ptr_step[gi]),
            .ptr       (ptr_val[gi])
         );
      end
   endgenerate

   assign accept    = (state_reg == ST_IDLE) && start;
   assign last_word = ((words_done_reg + LEN_W'(1)) == len_reg);

   // Next-state logic; grant is only looked at on word boundaries.
   always_comb begin
      state_next = state_reg;
      ptr_load   = 1'b0;
      ptr_step   = 2'b00;
      wd_inc     = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (start) begin
               ptr_load   = 1'b1;
               state_next = (len == '0) ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus_gnt) begin
               state_next = (mode_reg == MODE_FILL) ? ST_WR : ST_RD;
            end
         end
         ST_RD: begin
            ptr_step[SRC] = 1'b1;
            state_next    = ST_WR;
         end
         ST_WR: begin
            ptr_step[DST] = 1'b1;
            wd_inc        = 1'b1;
            if (last_word) begin
               state_next = ST_DONE;
            end else if (bus_gnt) begin
               state_next = (mode_reg == MODE_FILL) ? ST_WR : ST_RD;
            end else begin
               state_next = ST_REQ;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Output values for the cycle being entered, so the registered outputs
   // line up with the registered state. Pointers are sampled before they
   // step, except when a fill stays in WR and needs the following word.
   always_comb begin
      bus_req_next = (state_next == ST_REQ) || (state_next == ST_RD) ||
                     (state_next == ST_WR);
      busy_next    = (state_next != ST_IDLE);
      done_next    = (state_next == ST_DONE);
      we_next      = (state_next == ST_WR);
      addr_next    = '0;
      data_next    = '0;
      if (state_next == ST_RD) begin
         addr_next = ptr_val[SRC];
      end else if (state_next == ST_WR) begin
         addr_next = (state_reg == ST_WR) ? (ptr_val[DST] + WORD_STEP) : ptr_val[DST];
         data_next = (mode_reg == MODE_FILL) ? fill_reg : dataout;
      end
   end

   // State, request parameters, progress counter and output registers.
   always_ff @(posedge clock or posedge clr) begin
      if (clr) begin
         state_reg      <= ST_IDLE;
         mode_reg       <= MODE_COPY;
         len_reg        <= '0;
         fill_reg       <= '0;
         words_done_reg <= '0;
         data_reg       <= '0;
         addr_reg       <= '0;
         we_reg         <= 1'b0;
         bus_req_reg    <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg   <= state_next;
         data_reg    <= data_next;
         addr_reg    <= addr_next;
         we_reg      <= we_next;
         bus_req_reg <= bus_req_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         if (accept) begin
            mode_reg       <= mode;
            len_reg        <= len;
            fill_reg       <= fill_data;
            words_done_reg <= '0;
         end else if (wd_inc) begin
            words_done_reg <= words_done_reg + LEN_W'(1);
         end
      end
   end

   assign bus_req    = bus_req_reg;
   assign addr       = addr_reg;
   assign datain     = data_reg;
   assign we         = we_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign words_done = words_done_reg;

endmodule

// File: tb/tb_dmem_block_mover.sv
// Self-checking bench for dmem_block_mover: a word-addressed memory model
// answers the bus, and a transaction-level reference predicts the bus
// access sequence, completion time and final memory image.
module tb_dmem_block_mover;
   import dmem_mover_pkg::*;

   localparam int LEN_W = 8;
   localparam int MEM_WORDS = 1024;

   logic             clock;
   logic             clr;
   logic             start;
   logic             mode;
   logic [31:0]      src_addr;
   logic [31:0]      dst_addr;
   logic [LEN_W-1:0] len;
   logic [31:0]      fill_data;
   logic             bus_req;
   logic             bus_gnt;
   logic [31:0]      addr;
   logic [31:0]      datain;
   logic             we;
   logic [31:0]      dataout;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] words_done;

   dmem_block_mover #(.LEN_W(LEN_W)) dut (
      .clock      (clock),
      .clr        (clr),
      .start      (start),
      .mode       (mode),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
      .fill_data  (fill_data),
      .bus_req    (bus_req),
      .bus_gnt    (bus_gnt),
      .addr       (addr),
      .datain     (datain),
      .we         (we),
      .dataout    (dataout),
      .busy       (busy),
      .done       (done),
      .words_done (words_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory responder: aliases on addr[11:2]; the reference uses the same map.
   logic [31:0] mem [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   logic        pre_en;
   logic [9:0]  pre_idx;
   logic [31:0] pre_val;

   assign dataout = mem[addr[11:2]];

   always @(posedge clock) begin
      if (pre_en) mem[pre_idx] <= pre_val;
      else if (we) mem[addr[11:2]] <= datain;
   end

   typedef struct packed {
      logic [31:0] a;
      logic        w;
      logic [31:0] d;
   } acc_t;

   typedef struct {
      logic        m;
      logic [31:0] s;
      logic [31:0] d;
      int          n;
      logic [31:0] f;
      int          pulse;
      int          gap_from;
      int          gap_len;
      int          gap_after;
   } blk_t;

   acc_t got_q[$];
   acc_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   done_cyc;
   int   quiet_viol;
   logic busy_at_done, busy_after, done_after;
   logic [LEN_W-1:0] wd_at_done;

   // Reference: a block is an ordered list of word moves, each seeing the
   // effects of earlier ones. Bus view: one request cycle, then per word
   // an optional read and a write, with request cycles while ungranted.
   function automatic void model_block(input blk_t b);
      logic [31:0] sp, dp, v;
      acc_t e;
      exp_q.delete();
      sp = b.s & 32'hFFFF_FFFC;
      dp = b.d & 32'hFFFF_FFFC;
      if (b.n == 0) return;
      e = '{a: 32'h0, w: 1'b0, d: 32'h0};
      exp_q.push_back(e);
      for (int i = 0; i < b.n; i++) begin
         if (b.m == MODE_COPY) begin
            e = '{a: sp, w: 1'b0, d: 32'h0};
            exp_q.push_back(e);
            v = ref_mem[sp[11:2]];
            sp = sp + 32'd4;
         end else begin
            v = b.f;
         end
         e = '{a: dp, w: 1'b1, d: v};
         exp_q.push_back(e);
         ref_mem[dp[11:2]] = v;
         dp = dp + 32'd4;
         if (i + 1 == b.gap_after) begin
            for (int g = 0; g < b.gap_len; g++) begin
               e = '{a: 32'h0, w: 1'b0, d: 32'h0};
               exp_q.push_back(e);
            end
         end
      end
   endfunction

   task automatic preload_word(input int idx, input logic [31:0] val);
      pre_en  = 1'b1;
      pre_idx = idx[9:0];
      pre_val = val;
      @(posedge clock); #1;
      pre_en  = 1'b0;
      ref_mem[idx] = val;
   endtask

   // Issues one request and records every cycle of bus activity until done.
   task automatic run_block(input blk_t b);
      acc_t e;
      got_q.delete();
      quiet_viol   = 0;
      done_cyc     = 0;
      busy_at_done = 1'b0;
      wd_at_done   = '0;
      mode      = b.m;
      src_addr  = b.s;
      dst_addr  = b.d;
      len       = LEN_W'(b.n);
      fill_data = b.f;
      bus_gnt   = 1'b1;
      start     = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         bus_gnt = !(c >= b.gap_from && c < b.gap_from + b.gap_len);
         if (c == b.pulse) begin
            start     = 1'b1;
            mode      = ~b.m;
            src_addr  = $urandom;
            dst_addr  = $urandom;
            len       = LEN_W'($urandom_range(1, 5));
            fill_data = $urandom;
         end else begin
            start = 1'b0;
         end
         if (bus_req) begin
            e = '{a: addr, w: we, d: datain};
            got_q.push_back(e);
         end else if (we || addr != 32'h0 || datain != 32'h0) begin
            quiet_viol++;
         end
         if (done) begin
            done_cyc     = c;
            busy_at_done = busy;
            wd_at_done   = words_done;
            break;
         end
         @(posedge clock); #1;
      end
      start   = 1'b0;
      bus_gnt = 1'b1;
      @(posedge clock); #1;
      busy_after = busy;
      done_after = done;
   endtask

   task automatic test_reset();
      clr = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
      len = '0; fill_data = '0; bus_gnt = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
      @(posedge clock); #1;
      for (int k = 0; k < MEM_WORDS; k++) preload_word(k, $urandom);
      n_checks++;
      if ({bus_req, we, busy, done} !== 4'b0000 || addr !== 32'h0 ||
          datain !== 32'h0 || words_done !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b we=%b busy=%b done=%b addr=%h din=%h wd=%0d, all required 0",
                  bus_req, we, busy, done, addr, datain, words_done);
      end
      $display("reset: outputs req=%b we=%b busy=%b done=%b wd=%0d", bus_req, we, busy, done, words_done);
      clr = 1'b0;
      @(posedge clock); #1;
   endtask

   // Directed, grant-loss, busy-start and random blocks, issued back to back.
   task automatic test_blocks();
      blk_t tbl[$];
      blk_t b;
      int   exp_done, bad, diffs, first;
      preload_word(0, 32'h11);
      preload_word(1, 32'h22);
      preload_word(2, 32'h33);
      tbl.push_back('{MODE_COPY, 32'h0000_0000, 32'h0000_0040, 3, 32'h0, 0, 0, 0, 0});
      tbl.push_back('{MODE_FILL, 32'h0,         32'h0000_0080, 4, 32'hDEAD_BEEF, 0, 0, 0, 0});
      tbl.push_back('{MODE_COPY, 32'h0000_0010, 32'h0000_0050, 0, 32'h0, 0, 0, 0, 0});
      tbl.push_back('{MODE_COPY, 32'h0000_0100, 32'h0000_0180, 5, 32'h0, 3, 0, 0, 0});
      tbl.push_back('{MODE_COPY, 32'hFFFF_FFF8, 32'h0000_0200, 3, 32'h0, 0, 0, 0, 0});
      tbl.push_back('{MODE_COPY, 32'h0000_0240, 32'h0000_02C0, 4, 32'h0, 0, 5, 3, 2});
      tbl.push_back('{MODE_COPY, 32'h0000_0400, 32'h0000_0404, 6, 32'h0, 0, 0, 0, 0});
      tbl.push_back('{MODE_FILL, 32'h0,         32'h0000_0503, 2, 32'hA5A5_0F0F, 0, 0, 0, 0});
      tbl.push_back('{MODE_FILL, 32'h0,         32'hFFFF_FFFC, 2, 32'h1234_5678, 0, 0, 0, 0});
      for (int r = 0; r < 24; r++) begin
         b.m = 1'($urandom_range(0, 1));
         b.s = $urandom;
         b.d = $urandom;
         b.n = $urandom_range(0, 12);
         b.f = $urandom;
         b.pulse = (b.n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(2, b.n + 1) : 0;
         b.gap_from = 0; b.gap_len = 0; b.gap_after = 0;
         tbl.push_back(b);
      end
      foreach (tbl[t]) begin
         b = tbl[t];
         model_block(b);
         run_block(b);
         exp_done = (b.n == 0) ? 1 : exp_q.size() + 1;
         $display("txn %0d: mode=%0d src=%h dst=%h len=%0d accesses=%0d done_cycle=%0d wd=%0d",
                  t, b.m, b.s, b.d, b.n, got_q.size(), done_cyc, wd_at_done);

         n_checks++;
         if (done_cyc !== exp_done) begin
            n_fail++;
            $display("FAIL done_cycle txn %0d: got %0d, expected %0d", t, done_cyc, exp_done);
         end

         n_checks++;
         if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL trace_len txn %0d: got %0d bus cycles, expected %0d", t, got_q.size(), exp_q.size());
         end else begin
            bad = -1;
            foreach (exp_q[k]) if (bad < 0 && got_q[k] !== exp_q[k]) bad = k;
            if (bad >= 0) begin
               n_fail++;
               $display("FAIL trace txn %0d step %0d: got addr=%h we=%b din=%h, expected addr=%h we=%b din=%h",
                        t, bad, got_q[bad].a, got_q[bad].w, got_q[bad].d,
                        exp_q[bad].a, exp_q[bad].w, exp_q[bad].d);
            end
         end

         n_checks++;
         if (quiet_viol != 0) begin
            n_fail++;
            $display("FAIL port_quiet txn %0d: %0d cycles drove the port without bus_req, expected 0", t, quiet_viol);
         end

         n_checks++;
         if (wd_at_done !== LEN_W'(b.n)) begin
            n_fail++;
            $display("FAIL words_done txn %0d: got %0d, expected %0d", t, wd_at_done, b.n);
         end

         n_checks++;
         if ({busy_at_done, busy_after, done_after} !== 3'b100) begin
            n_fail++;
            $display("FAIL busy_done txn %0d: busy@done=%b busy_next=%b done_next=%b, expected 1 0 0",
                     t, busy_at_done, busy_after, done_after);
         end

         diffs = 0; first = -1;
         for (int k = 0; k < MEM_WORDS; k++) begin
            if (mem[k] !== ref_mem[k]) begin
               diffs++;
               if (first < 0) first = k;
            end
         end
         n_checks++;
         if (diffs != 0) begin
            n_fail++;
            $display("FAIL memory txn %0d: %0d words differ, first word %0d got %h expected %h",
                     t, diffs, first, mem[first], ref_mem[first]);
         end
      end
   endtask

   // Reset during the third write of a six-word copy, then a clean block.
   task automatic test_reset_mid_op();
      blk_t b, b2;
      int   diffs;
      b  = '{MODE_COPY, 32'h0000_0600, 32'h0000_0680, 6, 32'h0, 0, 0, 0, 0};
      b2 = b;
      b2.n = 2;
      model_block(b2);
      mode = b.m; src_addr = b.s; dst_addr = b.d; len = LEN_W'(b.n); fill_data = b.f;
      bus_gnt = 1'b1; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int c = 1; c < 7; c++) begin
         @(posedge clock); #1;
      end
      n_checks++;
      if (we !== 1'b1 || addr !== 32'h0000_0688) begin
         n_fail++;
         $display("FAIL third_write: got we=%b addr=%h, expected we=1 addr=00000688", we, addr);
      end
      #2 clr = 1'b1;
      #1;
      $display("reset_mid: we=%b req=%b busy=%b addr=%h wd=%0d", we, bus_req, busy, addr, words_done);
      n_checks++;
      if ({we, bus_req, busy, done} !== 4'b0000 || addr !== 32'h0 || words_done !== '0) begin
         n_fail++;
         $display("FAIL async_clear: we=%b req=%b busy=%b done=%b addr=%h wd=%0d, all required 0",
                  we, bus_req, busy, done, addr, words_done);
      end
      @(posedge clock); #1;
      clr = 1'b0;
      @(posedge clock); #1;
      diffs = 0;
      for (int k = 0; k < MEM_WORDS; k++) if (mem[k] !== ref_mem[k]) diffs++;
      n_checks++;
      if (diffs != 0) begin
         n_fail++;
         $display("FAIL abandoned_block: %0d words differ from a two-word partial copy, expected 0", diffs);
      end

      b = '{MODE_FILL, 32'h0, 32'h0000_0700, 3, 32'hC0FF_EE00, 0, 0, 0, 0};
      model_block(b);
      run_block(b);
      $display("post_reset txn: fill dst=%h len=%0d done_cycle=%0d wd=%0d", b.d, b.n, done_cyc, wd_at_done);
      n_checks++;
      if (done_cyc !== b.n + 2 || wd_at_done !== LEN_W'(b.n)) begin
         n_fail++;
         $display("FAIL post_reset_block: done_cycle=%0d wd=%0d, expected %0d and %0d",
                  done_cyc, wd_at_done, b.n + 2, b.n);
      end
      diffs = 0;
      for (int k = 0; k < MEM_WORDS; k++) if (mem[k] !== ref_mem[k]) diffs++;
      n_checks++;
      if (diffs != 0) begin
         n_fail++;
         $display("FAIL post_reset_memory: %0d words differ, expected 0", diffs);
      end
   endtask

   initial begin
      test_reset();
      test_blocks();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
